pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program-counter unit for the fetch stage of the pipelined CPU. It generalises the plain stalled PC register in four ways:
- configurable width, reset vector and exception vector;
- prioritised redirect and exception handling;
- a pending-redirect buffer, so a branch resolved during a stall is not lost;
- halt/resume control.

It drives the instruction-memory address and a fetch-valid qualifier into IF.

Parameters:
WIDTH, 32, PC width in bits.
RESET_VECTOR, 0, PC value loaded by reset.
EXC_VECTOR, 32'h0000_0080, PC value loaded on an exception or a misaligned redirect.
INC_BYTES, 4, sequential increment; must be a power of two ≥1. ALIGN_BITS = log2(INC_BYTES).

Ports:
CLOCK  input  1  clock; all state updates on posedge.
RESET  input  1  synchronous, active-high reset.
STALL  input  1  hazard stall from the hazard unit; holds the PC.
redirect_valid  input  1  branch/jump resolved taken (EX stage).
redirect_target  input  WIDTH  target address for redirect_valid.
exc_valid  input  1  exception/trap request; overrides everything except RESET.
halt_req  input  1  stop fetching (HALT instruction decoded).
resume  input  1  leave HALT.
pc_out  output  WIDTH  current fetch address.
pc_seq  output  WIDTH  combinational pc_out + INC_BYTES, wrapping modulo 2^WIDTH.
fetch_valid  output  1  pc_out is a real fetch this cycle.
redirect_pending  output  1  a redirect is buffered awaiting stall release.
misalign_err  output  1  one-cycle pulse: a redirect target was misaligned.

Behaviour:
- Reset. RESET=1 at a posedge sets:
  - pc_out=RESET_VECTOR
  - state=BOOT
  - fetch_valid=0
  - redirect_pending=0 and pending target cleared
  - misalign_err=0

  Reset wins over all other inputs, including mid-HALT and mid-PENDING.
- States: BOOT, RUN, PEND, HALT. fetch_valid=1 only in RUN and PEND (PEND fetch is still stalled, but the address is valid).
- Misaligned redirect: a redirect with redirect_target[ALIGN_BITS-1:0]≠0 (ALIGN_BITS=0 means never misaligned) is handled as an exception:
  - pc_out←EXC_VECTOR
  - misalign_err=1 for the next cycle only
  - the target is discarded
- BOOT: the next posedge with RESET=0 goes to RUN; pc_out is unchanged. The first fetch is therefore RESET_VECTOR, one cycle after reset release.
- RUN: evaluated at posedge in this priority order:
  1. exc_valid: pc_out←EXC_VECTOR, stay RUN. Applies even when STALL=1.
  2. redirect_valid & misaligned: handled as the misaligned exception above.
  3. redirect_valid & STALL=0: pc_out←redirect_target.
  4. redirect_valid & STALL=1: latch the target, redirect_pending←1, go to PEND; pc_out held.
  5. STALL=1: hold pc_out.
  6. halt_req: hold pc_out, go to HALT.
  7. Otherwise: pc_out←pc_seq.
- PEND: at posedge, in this order:
  1. exc_valid: pc_out←EXC_VECTOR, clear pending, go to RUN.
  2. New aligned redirect_valid: overwrites the buffered target (most recent wins).
  3. STALL=0: pc_out←buffered target (or the new target if one arrived the same cycle), clear pending, go to RUN.
  4. STALL=1: hold pc_out.

  A misaligned redirect in PEND is handled as the misaligned exception and clears pending. halt_req is ignored in PEND.
- HALT: fetch_valid=0, pc_out held. At posedge, in this order:
  1. exc_valid: pc_out←EXC_VECTOR, go to RUN.
  2. redirect_valid: apply as in RUN with STALL forced 0, go to RUN.
  3. resume: pc_out←pc_seq, go to RUN.

  STALL has no effect in HALT.
- Latency: every PC update is visible on pc_out one cycle after the sampling edge. There is no combinational path from inputs to pc_out or fetch_valid.
- Wrap-around: pc_seq from 2^WIDTH−INC_BYTES is 0, with no flag.
- redirect_pending equals (state==PEND).

Test Plan:
1. RESET=1 for 2 cycles, then release:
   - at the first edge after release, pc_out=0 and fetch_valid goes 0→1;
   - the next edges give 4, 8, 12.
2. Running at 0x10 with STALL=1 for 3 cycles:
   - pc_out holds 0x10 and fetch_valid stays 1;
   - after STALL drops, 0x14, 0x18.
3. At 0x20, STALL=1 and redirect_valid=1 with target 0x100 for one cycle, STALL held 2 more cycles:
   - pc_out stays 0x20 and redirect_pending=1;
   - on the STALL release edge, pc_out=0x100 and redirect_pending=0;
   - a second redirect to 0x200 during the stall makes pc_out=0x200 instead.
4. exc_valid together with redirect_valid (target 0x300) and STALL=1:
   - pc_out=0x80 next cycle, pending cleared;
   - a redirect to 0x102 (misaligned) also gives pc_out=0x80, with misalign_err high for exactly one cycle.
5. halt_req at pc_out=0x40:
   - pc_out holds 0x40 and fetch_valid=0 for 5 cycles with STALL toggling;
   - after a resume pulse, pc_out=0x44 and fetch_valid=1.
6. Wrap and reset mid-operation, with WIDTH=16:
   - from 0xFFFC the next value is 0x0000;
   - asserting RESET while in PEND returns pc_out to RESET_VECTOR with redirect_pending=0, and the buffered target is never taken.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the pipeline control (master) and the PC sequencer (slave).
// The master drives stall/redirect/exception/halt controls; the slave returns the fetch address.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             STALL;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             exc_valid;
    logic             halt_req;
    logic             resume;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_seq;
    logic             fetch_valid;
    logic             redirect_pending;
    logic             misalign_err;

    modport master (
        output STALL, redirect_valid, redirect_target, exc_valid, halt_req, resume,
        input  pc_out, pc_seq, fetch_valid, redirect_pending, misalign_err
    );

    modport slave (
        input  STALL, redirect_valid, redirect_target, exc_valid, halt_req, resume,
        output pc_out, pc_seq, fetch_valid, redirect_pending, misalign_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential stepping, prioritised exception/redirect handling,
// a one-entry buffer that keeps a redirect resolved during a stall, and halt/resume control.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
    parameter int unsigned      INC_BYTES    = 4
) (
    input logic           CLOCK,
    input logic           RESET,
    pc_sequencer_if.slave bus
);
    // INC_BYTES is a power of two, so INC_BYTES-1 masks exactly the low ALIGN_BITS bits.
    localparam logic [WIDTH-1:0] INC        = WIDTH'(INC_BYTES);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC_BYTES - 1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_PEND,
        S_HALT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_target;
    logic             r_misalign;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_target_next;
    logic             w_misalign_next;
    logic [WIDTH-1:0] w_pc_seq;
    logic [WIDTH-1:0] w_pend_target;
    logic             w_misaligned;
    logic             w_take_exc;

    assign w_pc_seq      = r_pc + INC;
    assign w_misaligned  = bus.redirect_valid && ((bus.redirect_target & ALIGN_MASK) != '0);
    assign w_take_exc    = bus.exc_valid || w_misaligned;
    // In PEND a fresh redirect replaces the buffered one: most recent wins.
    assign w_pend_target = bus.redirect_valid ? bus.redirect_target : r_target;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VECTOR;
            r_target   <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_target   <= w_target_next;
            r_misalign <= w_misalign_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_target_next   = r_target;
        w_misalign_next = 1'b0;

        unique case (r_state)
            S_BOOT: w_state_next = S_RUN;
            S_RUN: begin
                if (bus.redirect_valid && !bus.STALL) begin
                    w_pc_next = bus.redirect_target;
                end else if (bus.redirect_valid) begin
                    w_target_next = bus.redirect_target;
                    w_state_next  = S_PEND;
                end else if (!bus.STALL) begin
                    if (bus.halt_req) w_state_next = S_HALT;
                    else              w_pc_next    = w_pc_seq;
                end
            end
            S_PEND: begin
                if (!bus.STALL) begin
                    w_pc_next     = w_pend_target;
                    w_target_next = '0;
                    w_state_next  = S_RUN;
                end else begin
                    w_target_next = w_pend_target;
                end
            end
            S_HALT: begin
                if (bus.redirect_valid) begin
                    w_pc_next    = bus.redirect_target;
                    w_state_next = S_RUN;
                end else if (bus.resume) begin
                    w_pc_next    = w_pc_seq;
                    w_state_next = S_RUN;
                end
            end
        endcase

        // Exceptions (including a misaligned redirect) override every non-boot decision above.
        if (r_state != S_BOOT && w_take_exc) begin
            w_pc_next       = EXC_VECTOR;
            w_target_next   = '0;
            w_state_next    = S_RUN;
            w_misalign_next = !bus.exc_valid;
        end
    end

    assign bus.pc_out           = r_pc;
    assign bus.pc_seq           = w_pc_seq;
    assign bus.fetch_valid      = (r_state == S_RUN) || (r_state == S_PEND);
    assign bus.redirect_pending = (r_state == S_PEND);
    assign bus.misalign_err     = r_misalign;
endmodule

// File: tb/tb_pc_sequencer.sv
// Drives a 32-bit and a 16-bit pc_sequencer with the same directed stimulus and checks both
// every cycle against a behavioural model, plus hand-computed literal expectations.
module tb_pc_sequencer;
    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        stall, rv, exc, hreq, res;
    logic [31:0] rt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 CLOCK = ~CLOCK;

    pc_sequencer_if #(.WIDTH(32)) bus32 ();
    pc_sequencer_if #(.WIDTH(16)) bus16 ();

    assign bus32.STALL           = stall;
    assign bus32.redirect_valid  = rv;
    assign bus32.redirect_target = rt;
    assign bus32.exc_valid       = exc;
    assign bus32.halt_req        = hreq;
    assign bus32.resume          = res;
    assign bus16.STALL           = stall;
    assign bus16.redirect_valid  = rv;
    assign bus16.redirect_target = rt[15:0];
    assign bus16.exc_valid       = exc;
    assign bus16.halt_req        = hreq;
    assign bus16.resume          = res;

    pc_sequencer dut32 (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus  (bus32)
    );

    pc_sequencer #(
        .WIDTH       (16),
        .RESET_VECTOR(16'h0000),
        .EXC_VECTOR  (16'h0080),
        .INC_BYTES   (4)
    ) dut16 (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus  (bus16)
    );

    // Abstract model: flags for "booting", "halted" and "holding a redirect", plus PC and target.
    typedef struct packed {
        logic        boot;
        logic        halted;
        logic        pend;
        logic        mis;
        logic [31:0] pc;
        logic [31:0] tgt;
    } m_t;

    m_t m32, m16;

    function automatic m_t step(input m_t s, input logic [31:0] mask, input logic rst,
                                input logic stl, input logic rdv, input logic [31:0] rdt,
                                input logic ex, input logic hr, input logic rs);
        m_t          n;
        logic [31:0] t;
        logic [31:0] sel;
        logic        misal;
        n     = s;
        n.mis = 1'b0;
        t     = rdt & mask;
        misal = rdv && (t[1:0] != 2'b00);
        if (rst) begin
            n = '{boot: 1'b1, halted: 1'b0, pend: 1'b0, mis: 1'b0, pc: 32'h0, tgt: 32'h0};
        end else if (s.boot) begin
            n.boot = 1'b0;
        end else if (ex || misal) begin
            n.pc     = 32'h80 & mask;
            n.halted = 1'b0;
            n.pend   = 1'b0;
            n.mis    = ~ex;
        end else if (s.halted) begin
            if (rdv) begin
                n.pc     = t;
                n.halted = 1'b0;
            end else if (rs) begin
                n.pc     = (s.pc + 32'd4) & mask;
                n.halted = 1'b0;
            end
        end else if (s.pend) begin
            sel = rdv ? t : s.tgt;
            if (!stl) begin
                n.pc   = sel;
                n.pend = 1'b0;
            end else begin
                n.tgt = sel;
            end
        end else if (rdv) begin
            if (stl) begin
                n.pend = 1'b1;
                n.tgt  = t;
            end else begin
                n.pc = t;
            end
        end else if (!stl) begin
            if (hr) n.halted = 1'b1;
            else    n.pc     = (s.pc + 32'd4) & mask;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLOCK) begin
        m32 <= step(m32, 32'hFFFF_FFFF, RESET, stall, rv, rt, exc, hreq, res);
        m16 <= step(m16, 32'h0000_FFFF, RESET, stall, rv, rt, exc, hreq, res);
        if (RESET) chk_en <= 1'b1;
    end

    always @(negedge CLOCK) begin
        if (chk_en) begin
            check("cmp32_pc",   bus32.pc_out, m32.pc);
            check("cmp32_seq",  bus32.pc_seq, m32.pc + 32'd4);
            check("cmp32_fv",   32'(bus32.fetch_valid), 32'(!m32.boot && !m32.halted));
            check("cmp32_pend", 32'(bus32.redirect_pending), 32'(m32.pend));
            check("cmp32_mis",  32'(bus32.misalign_err), 32'(m32.mis));
            check("cmp16_pc",   32'(bus16.pc_out), m16.pc);
            check("cmp16_seq",  32'(bus16.pc_seq), (m16.pc + 32'd4) & 32'h0000_FFFF);
            check("cmp16_fv",   32'(bus16.fetch_valid), 32'(!m16.boot && !m16.halted));
            check("cmp16_pend", 32'(bus16.redirect_pending), 32'(m16.pend));
            check("cmp16_mis",  32'(bus16.misalign_err), 32'(m16.mis));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    initial begin
        RESET = 1'b1; stall = 1'b0; rv = 1'b0; rt = 32'h0; exc = 1'b0; hreq = 1'b0; res = 1'b0;
        cyc(2);
        check("t1_rst_pc", bus32.pc_out, 32'h0);
        check("t1_rst_fv", 32'(bus32.fetch_valid), 32'h0);
        check("t1_rst_pend", 32'(bus32.redirect_pending), 32'h0);
        RESET = 1'b0;
        cyc(1);
        check("t1_boot_pc", bus32.pc_out, 32'h0);
        check("t1_boot_fv", 32'(bus32.fetch_valid), 32'h1);
        cyc(1); check("t1_pc4", bus32.pc_out, 32'h4);
        cyc(1); check("t1_pc8", bus32.pc_out, 32'h8);
        cyc(1); check("t1_pc12", bus32.pc_out, 32'hC);

        cyc(1); check("t2_pc10", bus32.pc_out, 32'h10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("t2_hold_pc", bus32.pc_out, 32'h10);
            check("t2_hold_fv", 32'(bus32.fetch_valid), 32'h1);
        end
        stall = 1'b0;
        cyc(1); check("t2_pc14", bus32.pc_out, 32'h14);
        cyc(1); check("t2_pc18", bus32.pc_out, 32'h18);

        cyc(2); check("t3_pc20", bus32.pc_out, 32'h20);
        stall = 1'b1; rv = 1'b1; rt = 32'h100;
        cyc(1);
        rv = 1'b0;
        check("t3_pend_pc", bus32.pc_out, 32'h20);
        check("t3_pend_flag", 32'(bus32.redirect_pending), 32'h1);
        cyc(2); check("t3_still_pc", bus32.pc_out, 32'h20);
        stall = 1'b0;
        cyc(1);
        check("t3_taken_pc", bus32.pc_out, 32'h100);
        check("t3_taken_flag", 32'(bus32.redirect_pending), 32'h0);
        stall = 1'b1; rv = 1'b1; rt = 32'h180;
        cyc(1);
        rt = 32'h200;
        cyc(1);
        rv = 1'b0;
        cyc(1);
        stall = 1'b0;
        cyc(1); check("t3_newest_pc", bus32.pc_out, 32'h200);

        stall = 1'b1; rv = 1'b1; rt = 32'h300;
        cyc(1);
        exc = 1'b1;
        cyc(1);
        exc = 1'b0; rv = 1'b0; stall = 1'b0;
        check("t4_exc_pc", bus32.pc_out, 32'h80);
        check("t4_exc_pend", 32'(bus32.redirect_pending), 32'h0);
        check("t4_exc_mis", 32'(bus32.misalign_err), 32'h0);
        cyc(1);
        rv = 1'b1; rt = 32'h102;
        cyc(1);
        rv = 1'b0;
        check("t4_mis_pc", bus32.pc_out, 32'h80);
        check("t4_mis_pulse", 32'(bus32.misalign_err), 32'h1);
        cyc(1);
        check("t4_mis_clear", 32'(bus32.misalign_err), 32'h0);
        check("t4_mis_next", bus32.pc_out, 32'h84);
        stall = 1'b1; rv = 1'b1; rt = 32'h400;
        cyc(1);
        rt = 32'h402;
        cyc(1);
        stall = 1'b0; rv = 1'b0;
        check("t4_pmis_pc", bus32.pc_out, 32'h80);
        check("t4_pmis_pend", 32'(bus32.redirect_pending), 32'h0);
        cyc(1);

        rv = 1'b1; rt = 32'h40;
        cyc(1);
        rv = 1'b0; hreq = 1'b1;
        cyc(1);
        hreq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stall = i[0];
            cyc(1);
            check("t5_halt_pc", bus32.pc_out, 32'h40);
            check("t5_halt_fv", 32'(bus32.fetch_valid), 32'h0);
        end
        stall = 1'b0; res = 1'b1;
        cyc(1);
        res = 1'b0;
        check("t5_resume_pc", bus32.pc_out, 32'h44);
        check("t5_resume_fv", 32'(bus32.fetch_valid), 32'h1);
        hreq = 1'b1;
        cyc(1);
        hreq = 1'b0; rv = 1'b1; rt = 32'h60; stall = 1'b1;
        cyc(1);
        rv = 1'b0; stall = 1'b0;
        check("t5_hredir_pc", bus32.pc_out, 32'h60);

        rv = 1'b1; rt = 32'hFFFC;
        cyc(1);
        rv = 1'b0;
        check("t6_seq16_wrap", 32'(bus16.pc_seq), 32'h0);
        check("t6_seq32_nowrap", bus32.pc_seq, 32'h1_0000);
        cyc(1);
        check("t6_pc16_wrap", 32'(bus16.pc_out), 32'h0);
        stall = 1'b1; rv = 1'b1; rt = 32'h500;
        cyc(1);
        rv = 1'b0; RESET = 1'b1;
        cyc(1);
        RESET = 1'b0; stall = 1'b0;
        check("t6_rst_pc16", 32'(bus16.pc_out), 32'h0);
        check("t6_rst_pend16", 32'(bus16.redirect_pending), 32'h0);
        cyc(1);
        cyc(1);
        check("t6_after_pc16", 32'(bus16.pc_out), 32'h4);
        check("t6_after_pc32", bus32.pc_out, 32'h4);
        @(negedge CLOCK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
